// File: rtl/au_arb.sv
// au_arb: two-requester round-robin arbiter and sequencer for the 3-bit au.
// Accepts one command at a time, drives registered operands to the
// combinational au, captures its result one cycle later and returns it to
// the winning requester through a valid/ready response handshake.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready/a/b/op          command handshake per requester (ready is combinational)
//   rspN_valid/ready                 response handshake per requester
//   rsp_y, rsp_ov/gt/lt/eq           captured au result (shared by both requesters)
//   au_a, au_b, au_op                registered operands to au
//   au_y, au_ov/gt/lt/eq             result from au
//   busy                             high whenever not idle
//   last_gnt                         index of most recent grant
module au_arb #(
    parameter int unsigned W   = 3,
    parameter int unsigned OPW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp_y,
    output logic           rsp_ov,
    output logic           rsp_gt,
    output logic           rsp_lt,
    output logic           rsp_eq,
    output logic [W-1:0]   au_a,
    output logic [W-1:0]   au_b,
    output logic [OPW-1:0] au_op,
    input  logic [W-1:0]   au_y,
    input  logic           au_ov,
    input  logic           au_gt,
    input  logic           au_lt,
    input  logic           au_eq,
    output logic           busy,
    output logic           last_gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_busy;
    logic           r_prio;
    logic           r_sel;
    logic           r_last_gnt;
    logic [W-1:0]   r_au_a;
    logic [W-1:0]   r_au_b;
    logic [OPW-1:0] r_au_op;
    logic [W-1:0]   r_rsp_y;
    logic           r_rsp_ov;
    logic           r_rsp_gt;
    logic           r_rsp_lt;
    logic           r_rsp_eq;
    logic           r_rsp0_valid;
    logic           r_rsp1_valid;

    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_load;
    logic           w_capture;
    logic           w_done;

    // Next-state and per-state strobes; grants exist only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                // prio breaks ties only; a lone requester always wins
                w_gnt0 = req0_valid & (~r_prio | ~req1_valid);
                w_gnt1 = req1_valid & ( r_prio | ~req0_valid);
                w_load = w_gnt0 | w_gnt1;
                if (w_load) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                // only the selected requester's ready can retire the response
                w_done = r_sel ? rsp1_ready : rsp0_ready;
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; busy registered from the next state so it tracks r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Operand latch on grant, result capture after EXEC, response retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio       <= 1'b0;
            r_sel        <= 1'b0;
            r_last_gnt   <= 1'b0;
            r_au_a       <= '0;
            r_au_b       <= '0;
            r_au_op      <= '0;
            r_rsp_y      <= '0;
            r_rsp_ov     <= 1'b0;
            r_rsp_gt     <= 1'b0;
            r_rsp_lt     <= 1'b0;
            r_rsp_eq     <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_au_a     <= w_gnt1 ? req1_a  : req0_a;
                r_au_b     <= w_gnt1 ? req1_b  : req0_b;
                r_au_op    <= w_gnt1 ? req1_op : req0_op;
                r_sel      <= w_gnt1;
                r_last_gnt <= w_gnt1;
                r_prio     <= ~w_gnt1;
            end
            if (w_capture) begin
                r_rsp_y      <= au_y;
                r_rsp_ov     <= au_ov;
                r_rsp_gt     <= au_gt;
                r_rsp_lt     <= au_lt;
                r_rsp_eq     <= au_eq;
                r_rsp0_valid <= ~r_sel;
                r_rsp1_valid <=  r_sel;
            end
            if (w_done) begin
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_y      = r_rsp_y;
    assign rsp_ov     = r_rsp_ov;
    assign rsp_gt     = r_rsp_gt;
    assign rsp_lt     = r_rsp_lt;
    assign rsp_eq     = r_rsp_eq;
    assign au_a       = r_au_a;
    assign au_b       = r_au_b;
    assign au_op      = r_au_op;
    assign busy       = r_busy;
    assign last_gnt   = r_last_gnt;

endmodule

// File: tb/tb_au_arb.sv
// tb_au_arb: self-checking bench for au_arb with a behavioural au attached.
module tb_au_arb;

    localparam int unsigned W   = 3;
    localparam int unsigned OPW = 2;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req0_ready;
    logic [W-1:0]   req0_a, req0_b;
    logic [OPW-1:0] req0_op;
    logic           req1_valid, req1_ready;
    logic [W-1:0]   req1_a, req1_b;
    logic [OPW-1:0] req1_op;
    logic           rsp0_valid, rsp0_ready;
    logic           rsp1_valid, rsp1_ready;
    logic [W-1:0]   rsp_y;
    logic           rsp_ov, rsp_gt, rsp_lt, rsp_eq;
    logic [W-1:0]   au_a, au_b;
    logic [OPW-1:0] au_op;
    logic [W-1:0]   au_y;
    logic           au_ov, au_gt, au_lt, au_eq;
    logic           busy, last_gnt;

    int  checks;
    int  errors;
    bit  m_prio;   // reference model: requester that wins the next tie

    // Behavioural au: add, sub, and, xor; {y, ov, gt, lt, eq}
    function automatic logic [6:0] au_ref(input logic [2:0] a, input logic [2:0] b,
                                          input logic [1:0] op);
        logic [3:0] s;
        logic [2:0] y;
        logic       ov;
        s  = '0;
        y  = '0;
        ov = 1'b0;
        case (op)
            2'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[2:0]; ov = s[3]; end
            2'd1: begin y = a - b; ov = (a < b); end
            2'd2: begin y = a & b; end
            default: begin y = a ^ b; end
        endcase
        return {y, ov, (a > b), (a < b), (a == b)};
    endfunction

    logic [6:0] w_au;
    assign w_au = au_ref(au_a, au_b, au_op);
    assign au_y  = w_au[6:4];
    assign au_ov = w_au[3];
    assign au_gt = w_au[2];
    assign au_lt = w_au[1];
    assign au_eq = w_au[0];

    au_arb #(.W(W), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .rsp_ov(rsp_ov), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq),
        .au_a(au_a), .au_b(au_b), .au_op(au_op),
        .au_y(au_y), .au_ov(au_ov), .au_gt(au_gt), .au_lt(au_lt), .au_eq(au_eq),
        .busy(busy), .last_gnt(last_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic rand_cmds();
        req0_a  = W'($urandom);
        req0_b  = W'($urandom);
        req0_op = OPW'($urandom);
        req1_a  = W'($urandom);
        req1_b  = W'($urandom);
        req1_op = OPW'($urandom);
    endtask

    task automatic test_reset();
        logic [18:0] obs;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rand_cmds();
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            rsp0_ready = 1'($urandom);
            rsp1_ready = 1'($urandom);
            #1;
            obs = {au_a, au_b, au_op, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq,
                   rsp0_valid, rsp1_valid, busy, last_gnt};
            checks++;
            if (obs !== 19'd0) begin
                errors++;
                $display("FAIL reset_outputs got %h want 0", obs);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        rst_n      = 1'b1;
        m_prio     = 1'b0;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 10", {req1_ready, req0_ready});
        end
        // valid withdrawn before the edge: no grant, no prio change
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, last_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_withdraw got %b want 00", {busy, last_gnt});
        end
    endtask

    task automatic test_single();
        logic [6:0] exp;
        @(negedge clk);
        req0_a = 3'b010; req0_b = 3'b011; req0_op = 2'b00;
        req0_valid = 1'b1; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        exp = au_ref(3'b010, 3'b011, 2'b00);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL single_ready got %b want 01", {req1_ready, req0_ready});
        end
        m_prio = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        rand_cmds();
        checks++;
        if ({au_a, au_b, au_op, busy, last_gnt, rsp0_valid} !== {8'b010_011_00, 3'b100}) begin
            errors++;
            $display("FAIL single_exec got %b want %b",
                     {au_a, au_b, au_op, busy, last_gnt, rsp0_valid}, {8'b010_011_00, 3'b100});
        end
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp0_valid, rsp_y, rsp_ov} !== {2'b01, 3'b101, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp got %b want %b",
                     {rsp1_valid, rsp0_valid, rsp_y, rsp_ov}, {2'b01, 3'b101, 1'b0});
        end
        checks++;
        if ({rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq} !== exp) begin
            errors++;
            $display("FAIL single_flags got %b want %b", {rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq}, exp);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        checks++;
        if ({rsp0_valid, busy, au_a} !== {2'b00, 3'b010}) begin
            errors++;
            $display("FAIL single_done got %b want 00010", {rsp0_valid, busy, au_a});
        end
    endtask

    task automatic test_contention();
        logic [6:0] exp;
        logic [1:0] exp_rdy;
        bit         sel;
        exp = '0;
        sel = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rand_cmds();
            req0_valid = 1'b1; req1_valid = 1'b1;
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            #1;
            exp_rdy = (c % 3 == 0) ? (m_prio ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({req1_ready, req0_ready} !== exp_rdy) begin
                errors++;
                $display("FAIL contention_ready cyc %0d got %b want %b", c, {req1_ready, req0_ready}, exp_rdy);
            end
            if (c % 3 == 0) begin
                sel    = m_prio;
                exp    = sel ? au_ref(req1_a, req1_b, req1_op) : au_ref(req0_a, req0_b, req0_op);
                m_prio = ~sel;
            end else if (c % 3 == 1) begin
                checks++;
                if ({busy, last_gnt} !== {1'b1, sel}) begin
                    errors++;
                    $display("FAIL contention_last_gnt cyc %0d got %b want %b", c, {busy, last_gnt}, {1'b1, sel});
                end
            end else begin
                checks++;
                if ({rsp1_valid, rsp0_valid, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq} !== {sel, ~sel, exp}) begin
                    errors++;
                    $display("FAIL contention_rsp cyc %0d got %b want %b", c,
                             {rsp1_valid, rsp0_valid, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq}, {sel, ~sel, exp});
                end
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [6:0] exp0;
        logic [6:0] exp1;
        @(negedge clk);
        rand_cmds();
        req0_valid = 1'b1; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        exp0 = au_ref(req0_a, req0_b, req0_op);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept got %b want 1", req0_ready);
        end
        m_prio = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a = W'($urandom); req1_b = W'($urandom); req1_op = OPW'($urandom);
        exp1 = au_ref(req1_a, req1_b, req1_op);
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_exec_ready got %b want 0", req1_ready);
        end
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            rsp1_ready = 1'($urandom);
            #1;
            checks++;
            if ({rsp0_valid, req1_ready, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq} !== {2'b10, exp0}) begin
                errors++;
                $display("FAIL bp_stall cyc %0d got %b want %b", k,
                         {rsp0_valid, req1_ready, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq}, {2'b10, exp0});
            end
            @(negedge clk);
        end
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        checks++;
        if ({rsp0_valid, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got %b want 01", {rsp0_valid, req1_ready});
        end
        m_prio = 1'b0;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp0_valid, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq} !== {2'b10, exp1}) begin
            errors++;
            $display("FAIL bp_second_rsp got %b want %b",
                     {rsp1_valid, rsp0_valid, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq}, {2'b10, exp1});
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rand_cmds();
        req1_valid = 1'b1; req0_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_accept got %b want 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp1_valid, busy, last_gnt} !== 3'b111) begin
            errors++;
            $display("FAIL rmid_resp got %b want 111", {rsp1_valid, busy, last_gnt});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp1_valid, busy, last_gnt, au_a, au_b, au_op} !== 11'd0) begin
            errors++;
            $display("FAIL rmid_async got %b want 0", {rsp1_valid, busy, last_gnt, au_a, au_b, au_op});
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_prio = 1'b0;
        rand_cmds();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rmid_first_grant got %b want 01", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_idle got %b want 0", busy);
        end
    endtask

    task automatic test_sweep();
        logic [6:0] exp;
        logic [2:0] a, b;
        logic [1:0] op;
        bit         who;
        int         n;
        int         nrsp;
        nrsp = 0;
        for (int idx = 0; idx < 64; idx++) begin
            op  = 2'(idx >> 4);
            a   = 3'(2 + ((idx >> 2) & 3));
            b   = 3'(2 + (idx & 3));
            who = 1'(idx & 1);
            exp = au_ref(a, b, op);
            @(negedge clk);
            rand_cmds();
            if (who) begin
                req1_a = a; req1_b = b; req1_op = op;
            end else begin
                req0_a = a; req0_b = b; req0_op = op;
            end
            req0_valid = ~who; req1_valid = who;
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== {who, ~who}) begin
                errors++;
                $display("FAIL sweep_ready idx %0d got %b want %b", idx, {req1_ready, req0_ready}, {who, ~who});
            end
            m_prio = ~who;
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            rand_cmds();
            n = 0;
            while (!(who ? rsp1_valid : rsp0_valid) && n < 5) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n !== 1) begin
                errors++;
                $display("FAIL sweep_latency idx %0d got %0d want 1", idx, n);
            end
            checks++;
            if ({rsp1_valid, rsp0_valid, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq} !== {who, ~who, exp}) begin
                errors++;
                $display("FAIL sweep_rsp idx %0d got %b want %b", idx,
                         {rsp1_valid, rsp0_valid, rsp_y, rsp_ov, rsp_gt, rsp_lt, rsp_eq}, {who, ~who, exp});
            end else begin
                nrsp++;
            end
            repeat ($urandom_range(0, 2)) begin
                if (who) rsp0_ready = 1'($urandom);
                else     rsp1_ready = 1'($urandom);
                @(negedge clk);
            end
            rsp0_ready = ~who; rsp1_ready = who;
            @(negedge clk);
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            #1;
            checks++;
            if ({rsp1_valid, rsp0_valid, busy} !== 3'b000) begin
                errors++;
                $display("FAIL sweep_retire idx %0d got %b want 000", idx, {rsp1_valid, rsp0_valid, busy});
            end
        end
        checks++;
        if (nrsp !== 64) begin
            errors++;
            $display("FAIL sweep_count got %0d want 64", nrsp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_prio = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
